mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 95 +++++++++
 tb/tb_mem_responder.sv | 129 ++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: 3-state (IDLE/ACCESS/RESP) word-array memory responder with b/h/w loads and stores
// Ports: clk, reset (async, active-high); req/memwrite/funct3/Adr/WriteData request, taken while ready=1;
//        done pulses one cycle per accepted request with ReadData/fault; led is the MMIO LED register.
// Optional MMIO LED register at word LED_ADDR: define MEM_RESPONDER_MMIO_LED_EN.
module mem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] LED_ADDR    = 32'h0000_FFF0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        memwrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] Adr,
  input  logic [31:0] WriteData,
  output logic        ready,
  output logic        done,
  output logic [31:0] ReadData,
  output logic        fault,
  output logic [7:0]  led
);
  localparam int AW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
`ifdef MEM_RESPONDER_MMIO_LED_EN
  localparam bit MMIO_EN = 1'b1;
`else
  localparam bit MMIO_EN = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state, state_nx;
  logic        we_q, flt_q, in_array, is_led, bad_f3, misal, flt_c, acc, wr_mem, wr_led;
  logic [2:0]  f3_q;
  logic [1:0]  sz;
  logic [3:0]  be;
  logic [7:0]  led_q;
  logic [AW-1:0] idx;
  logic [31:0] adr_q, wd_q, rd_q, wdat, word, sh, ld;
  logic [31:0] mem [DEPTH_WORDS];
  always_comb begin
    state_nx = state == IDLE ? (req ? ACCESS : IDLE) : state == ACCESS ? RESP : IDLE;
    ready    = state == IDLE;
    done     = state == RESP;
  end
  assign acc      = state == ACCESS;
  assign idx      = adr_q[AW+1:2];
  assign sz       = f3_q[1:0];
  assign in_array = adr_q[31:2] < 30'(DEPTH_WORDS);
  assign is_led   = MMIO_EN && adr_q[31:2] == LED_ADDR[31:2];
  assign bad_f3   = f3_q == 3'b011 || f3_q[2:1] == 2'b11;
  assign misal    = (sz == 2'b01 && adr_q[0]) || (sz == 2'b10 && adr_q[1:0] != 2'b00);
  // unsigned variants (100/101) are load-only
  assign flt_c    = bad_f3 || misal || (we_q && f3_q[2]) || !(in_array || is_led);
  assign be       = sz == 2'b00 ? 4'b0001 << adr_q[1:0] : sz == 2'b01 ? (adr_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  // replicate store data so every selected lane sees the right byte
  assign wdat     = sz == 2'b00 ? {4{wd_q[7:0]}} : sz == 2'b01 ? {2{wd_q[15:0]}} : wd_q;
  assign word     = is_led ? {24'b0, led_q} : mem[idx];
  assign sh       = word >> {adr_q[1:0], 3'b000};
  assign ld       = sz == 2'b00 ? {{24{sh[7] & ~f3_q[2]}}, sh[7:0]} :
                    sz == 2'b01 ? {{16{sh[15] & ~f3_q[2]}}, sh[15:0]} : sh;
  assign wr_mem   = acc && we_q && !flt_c && !is_led;
  assign wr_led   = acc && we_q && !flt_c && is_led && be[0];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      we_q  <= 1'b0;
      f3_q  <= 3'b000;
      adr_q <= '0;
      wd_q  <= '0;
      rd_q  <= '0;
      flt_q <= 1'b0;
      led_q <= 8'h00;
    end else begin
      state <= state_nx;
      if (ready && req) begin
        we_q  <= memwrite;
        f3_q  <= funct3;
        adr_q <= Adr;
        wd_q  <= WriteData;
      end
      if (acc) begin
        rd_q  <= flt_c ? '0 : ld;
        flt_q <= flt_c;
      end
      if (wr_led) led_q <= wdat[7:0];
    end
  end
  // array has no reset; a request aborted by reset never reaches ACCESS at a clock edge
  always_ff @(posedge clk) begin
    if (wr_mem)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= wdat[8*i +: 8];
  end
  assign ReadData = done ? rd_q : '0;
  assign fault    = done & flt_q;
  assign led      = led_q;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed self-checking bench for mem_responder
module tb_mem_responder;
  logic clk = 1'b0, reset = 1'b0, req = 1'b0, memwrite = 1'b0;
  logic [2:0] funct3 = 3'b000;
  logic [31:0] Adr = '0, WriteData = '0;
  logic ready, done, fault;
  logic [31:0] ReadData;
  logic [7:0] led;
  int n_chk = 0, n_pass = 0;
  logic [31:0] rd;
  logic flt;
  int lat;
  mem_responder dut (
    .clk(clk), .reset(reset), .req(req), .memwrite(memwrite), .funct3(funct3),
    .Adr(Adr), .WriteData(WriteData), .ready(ready), .done(done),
    .ReadData(ReadData), .fault(fault), .led(led)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic xfer(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                      output logic [31:0] r, output logic f, output int l);
    @(negedge clk);
    for (int i = 0; i < 4 && !ready; i++) @(negedge clk);
    req = 1'b1; memwrite = we; funct3 = f3; Adr = a; WriteData = wd;
    @(posedge clk);
    #1 req = 1'b0; memwrite = 1'b0; funct3 = 3'b111; Adr = '1; WriteData = '1;
    r = '0; f = 1'b0; l = 0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (done) begin
        l = i; r = ReadData; f = fault;
        break;
      end
    end
  endtask
  task automatic st(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd, input logic ef);
    xfer(1'b1, f3, a, wd, rd, flt, lat);
    check({tag, " fault"}, 32'(flt), 32'(ef));
    check({tag, " latency"}, 32'(lat), 32'd2);
  endtask
  task automatic ld(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] exp, input logic ef);
    xfer(1'b0, f3, a, 32'h0, rd, flt, lat);
    check({tag, " data"}, rd, exp);
    check({tag, " fault"}, 32'(flt), 32'(ef));
    check({tag, " latency"}, 32'(lat), 32'd2);
  endtask
  initial begin
    logic [5:0] pat;
    int cnt;
    #2 reset = 1'b1;
    #1;
    check("rst ready", 32'(ready), 32'd1);
    check("rst done", 32'(done), 32'd0);
    check("rst fault", 32'(fault), 32'd0);
    check("rst rdata", ReadData, 32'h0);
    check("rst led", 32'(led), 32'h0);
    @(negedge clk) reset = 1'b0;
    st("sw 10", 3'b010, 32'h10, 32'hDEADBEEF, 1'b0);
    ld("lw 10", 3'b010, 32'h10, 32'hDEADBEEF, 1'b0);
    st("sw 10b", 3'b010, 32'h10, 32'h11223344, 1'b0);
    st("sb 13", 3'b000, 32'h13, 32'h00000080, 1'b0);
    ld("lb 13", 3'b000, 32'h13, 32'hFFFFFF80, 1'b0);
    ld("lbu 13", 3'b100, 32'h13, 32'h00000080, 1'b0);
    ld("lw 10 after sb", 3'b010, 32'h10, 32'h80223344, 1'b0);
    ld("lh 12", 3'b001, 32'h12, 32'hFFFF8022, 1'b0);
    ld("lhu 10", 3'b101, 32'h10, 32'h00003344, 1'b0);
    st("sh 12", 3'b001, 32'h12, 32'h0000ABCD, 1'b0);
    ld("lw 10 after sh", 3'b010, 32'h10, 32'hABCD3344, 1'b0);
    st("sw 20", 3'b010, 32'h20, 32'h55667788, 1'b0);
    ld("lh 11 misaligned", 3'b001, 32'h11, 32'h0, 1'b1);
    st("sw 22 misaligned", 3'b010, 32'h22, 32'hCAFEF00D, 1'b1);
    ld("lw 20 unchanged", 3'b010, 32'h20, 32'h55667788, 1'b0);
    ld("f3 011", 3'b011, 32'h20, 32'h0, 1'b1);
    ld("f3 110", 3'b110, 32'h20, 32'h0, 1'b1);
    st("store f3 100", 3'b100, 32'h20, 32'h000000FF, 1'b1);
    ld("lw 20 after bad st", 3'b010, 32'h20, 32'h55667788, 1'b0);
    ld("lw 1000 oor", 3'b010, 32'h1000, 32'h0, 1'b1);
    st("sw FFC", 3'b010, 32'hFFC, 32'h01020304, 1'b0);
    ld("lw FFC", 3'b010, 32'hFFC, 32'h01020304, 1'b0);
`ifdef MEM_RESPONDER_MMIO_LED_EN
    st("sw led", 3'b010, 32'hFFF0, 32'h000000A5, 1'b0);
    check("led A5", 32'(led), 32'hA5);
    ld("lw led", 3'b010, 32'hFFF0, 32'h000000A5, 1'b0);
    ld("lb led", 3'b000, 32'hFFF0, 32'hFFFFFFA5, 1'b0);
    st("sb led lane1", 3'b000, 32'hFFF1, 32'h00000077, 1'b0);
    check("led lane1 ignored", 32'(led), 32'hA5);
`else
    st("sw led", 3'b010, 32'hFFF0, 32'h000000A5, 1'b1);
    check("led tied", 32'(led), 32'h0);
    ld("lw led", 3'b010, 32'hFFF0, 32'h0, 1'b1);
`endif
    @(negedge clk);
    for (int i = 0; i < 4 && !ready; i++) @(negedge clk);
    req = 1'b1; memwrite = 1'b0; funct3 = 3'b010; Adr = 32'h10;
    pat = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      pat = {pat[4:0], done};
    end
    req = 1'b0;
    check("b2b done pattern", 32'(pat), 32'(6'b010010));
    st("sw 40", 3'b010, 32'h40, 32'h0BADCAFE, 1'b0);
    @(negedge clk);
    for (int i = 0; i < 4 && !ready; i++) @(negedge clk);
    req = 1'b1; memwrite = 1'b1; funct3 = 3'b010; Adr = 32'h40; WriteData = 32'h12345678;
    @(posedge clk);
    #1 req = 1'b0; memwrite = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("abort ready", 32'(ready), 32'd1);
    check("abort done", 32'(done), 32'd0);
    check("abort rdata", ReadData, 32'h0);
    check("abort led", 32'(led), 32'h0);
    @(negedge clk) reset = 1'b0;
    cnt = 0;
    repeat (5) begin
      @(negedge clk);
      cnt += int'(done);
    end
    check("abort no done", 32'(cnt), 32'd0);
    ld("lw 40 prior", 3'b010, 32'h40, 32'h0BADCAFE, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
